// File: rtl/sdpram_arb_pkg.sv
// Shared types and helpers for the simple dual-port RAM arbiter.
package sdpram_arb_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RD_LAT     = 3;

  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping, and moves the pointer just past the winner.
module rr_arbiter
  import sdpram_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int ID_W = id_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    // k is the distance from the pointer; smallest eligible distance wins.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((i + N - int'(ptr_q)) % N) == k)) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = ID_W'(i);
        end
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (int'(gnt_id) == N - 1) ? '0 : ID_W'(int'(gnt_id) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sdpram_arbiter.sv
// Shares one simple dual-port RAM among NUM_REQ clients: writes on port A,
// reads on port B, with tagged read data steered back to the issuer.
module sdpram_arbiter
  import sdpram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic                          ram_wena,
  output logic [ADDR_WIDTH-1:0]         ram_addra,
  output logic [DATA_WIDTH-1:0]         ram_dina,
  output logic [ADDR_WIDTH-1:0]         ram_addrb,
  input  logic [DATA_WIDTH-1:0]         ram_doutb
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
  logic [ID_W-1:0]       wr_id, rd_id;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // No grants while reset is held, so nothing handshakes during reset.
  assign wr_req = rst ? '0 : (req_valid & req_we);
  assign rd_req = rst ? '0 : (req_valid & ~req_we);

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (wr_req),
    .gnt    (wr_gnt),
    .gnt_id (wr_id)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (rd_req),
    .gnt    (rd_gnt),
    .gnt_id (rd_id)
  );

  assign req_ready = wr_gnt | rd_gnt;

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == wr_id) begin
        wr_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (ID_W'(i) == rd_id) begin
        rd_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  logic                  ram_wena_q, ram_wena_d;
  logic [ADDR_WIDTH-1:0] ram_addra_q, ram_addra_d;
  logic [DATA_WIDTH-1:0] ram_dina_q, ram_dina_d;
  logic [ADDR_WIDTH-1:0] ram_addrb_q, ram_addrb_d;
  rd_tag_t               tag_q [RD_LAT+1];
  rd_tag_t               tag_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  busy_w;

  always_comb begin
    ram_wena_d  = |wr_gnt;
    ram_addra_d = (|wr_gnt) ? wr_addr : ram_addra_q;
    ram_dina_d  = (|wr_gnt) ? wr_data : ram_dina_q;
    ram_addrb_d = (|rd_gnt) ? rd_addr : ram_addrb_q;

    tag_d       = '0;
    tag_d.valid = |rd_gnt;
    tag_d.id    = TAG_ID_W'(rd_id);

    // The last tag stage lines up with ram_doutb for that read.
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = tag_q[RD_LAT].valid && (tag_q[RD_LAT].id == TAG_ID_W'(i));
    end
    rsp_data_d = tag_q[RD_LAT].valid ? ram_doutb : rsp_data_q;

    busy_w = 1'b0;
    for (int k = 0; k <= RD_LAT; k++) begin
      busy_w = busy_w | tag_q[k].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wena_q  <= 1'b0;
      ram_addra_q <= '0;
      ram_dina_q  <= '0;
      ram_addrb_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ram_wena_q  <= ram_wena_d;
      ram_addra_q <= ram_addra_d;
      ram_dina_q  <= ram_dina_d;
      ram_addrb_q <= ram_addrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tag_q[0]    <= tag_d;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign ram_wena  = ram_wena_q;
  assign ram_addra = ram_addra_q;
  assign ram_dina  = ram_dina_q;
  assign ram_addrb = ram_addrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_w;

endmodule
